multi_operand_adder: RTL

Sequential multi-operand adder: captures N_OPS unsigned operands of WIDTH bits on a start pulse, accumulates them one per clock, and presents a full-width sum plus a truncated result with an overflow flag. It is the parametrised, handshaked successor to the team's fixed-width combinational summing exercises. It is used wherever several small operands must be summed into a known result width with explicit overflow reporting.

---
 rtl/multi_add_pkg.sv | 16 +
 rtl/sum_trunc_sat.sv | 28 ++
 rtl/multi_operand_adder.sv | 127 ++++++++++++
 3 files changed

// File: rtl/multi_add_pkg.sv
// Shared definitions for the sequential multi-operand adder: FSM state encoding
// and the full-sum width computation.
package multi_add_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSum  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Width that holds the sum of n_ops unsigned operands of width bits without wrapping.
  function automatic int unsigned calc_sum_w(input int unsigned width, input int unsigned n_ops);
    return width + $clog2(n_ops);
  endfunction

endpackage

// File: rtl/sum_trunc_sat.sv
// Combinational truncation of the full sum to TRUNC_W bits with overflow detect.
// With MULTI_OPERAND_ADDER_SAT_EN defined, an overflowing sum saturates to all ones;
// otherwise the low TRUNC_W bits are passed through (wrap).
module sum_trunc_sat #(
  parameter int unsigned SUM_W   = 6,
  parameter int unsigned TRUNC_W = 4
) (
  input  logic [SUM_W-1:0]   sum_i,
  output logic [TRUNC_W-1:0] trunc_o,
  output logic               ovf_o
);

  if (TRUNC_W >= SUM_W) begin : g_full
    // Result width covers the whole sum, so overflow is impossible.
    assign ovf_o   = 1'b0;
    assign trunc_o = TRUNC_W'(sum_i);
  end else begin : g_trunc
    logic [TRUNC_W-1:0] low_bits;
    assign low_bits = sum_i[TRUNC_W-1:0];
    assign ovf_o    = |sum_i[SUM_W-1:TRUNC_W];
`ifdef MULTI_OPERAND_ADDER_SAT_EN
    assign trunc_o  = ovf_o ? {TRUNC_W{1'b1}} : low_bits;
`else
    assign trunc_o  = low_bits;
`endif
  end

endmodule

// File: rtl/multi_operand_adder.sv
// Sequential multi-operand adder: captures N_OPS operands on start, adds one per
// clock, then registers the full sum, a truncated sum and an overflow flag.
// Optional saturation of the truncated sum: MULTI_OPERAND_ADDER_SAT_EN.
module multi_operand_adder
  import multi_add_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned N_OPS   = 4,
  parameter int unsigned TRUNC_W = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic [N_OPS*WIDTH-1:0]                 ops,
  output logic                                   busy,
  output logic                                   done,
  output logic [calc_sum_w(WIDTH, N_OPS)-1:0]    sum,
  output logic [TRUNC_W-1:0]                     sum_trunc,
  output logic                                   ovf
);

  localparam int unsigned SumW = calc_sum_w(WIDTH, N_OPS);
  localparam int unsigned IdxW = $clog2(N_OPS);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  ops_q [N_OPS];
  logic [SumW-1:0]   acc_q, acc_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              busy_q, done_q, ovf_q;
  logic [SumW-1:0]   sum_q;
  logic [TRUNC_W-1:0] trunc_q;

  logic              capture;
  logic              load_res;
  logic [SumW-1:0]   acc_sum;
  logic [TRUNC_W-1:0] trunc_nxt;
  logic              ovf_nxt;

  assign acc_sum = acc_q + SumW'(ops_q[idx_q]);

  sum_trunc_sat #(
    .SUM_W  (SumW),
    .TRUNC_W(TRUNC_W)
  ) u_sum_trunc_sat (
    .sum_i  (acc_sum),
    .trunc_o(trunc_nxt),
    .ovf_o  (ovf_nxt)
  );

  // Next-state logic: capture on start in IDLE/DONE, accumulate one operand per cycle in SUM.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    capture  = 1'b0;
    load_res = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          capture = 1'b1;
          state_d = StSum;
        end
      end
      StSum: begin
        acc_d = acc_sum;
        idx_d = idx_q + 1'b1;
        if (idx_q == IdxW'(N_OPS - 1)) begin
          load_res = 1'b1;
          state_d  = StDone;
        end
      end
      StDone: begin
        if (start) begin
          capture = 1'b1;
          state_d = StSum;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (capture) begin
      acc_d = '0;
      idx_d = '0;
    end
  end

  // State, datapath and registered outputs; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      trunc_q <= '0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < int'(N_OPS); i++) begin
        ops_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      busy_q  <= (state_d == StSum);
      done_q  <= (state_d == StDone);
      if (capture) begin
        for (int i = 0; i < int'(N_OPS); i++) begin
          ops_q[i] <= ops[i*WIDTH +: WIDTH];
        end
      end
      if (load_res) begin
        sum_q   <= acc_sum;
        trunc_q <= trunc_nxt;
        ovf_q   <= ovf_nxt;
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign sum       = sum_q;
  assign sum_trunc = trunc_q;
  assign ovf       = ovf_q;

endmodule
